// File: rtl/pro_1.sv
// pro_1: fixed-time, four-way traffic-light controller.
// Round-robin right-of-way N -> E -> S -> W. Each approach runs
// green, then yellow, then an optional all-red clearance, then the
// next approach gets green.
//
// Ports:
//   clk  in   1  system clock, rising edge
//   rst  in   1  synchronous active-high reset
//   red  out  4  red lamp per approach   (bit0=N, bit1=E, bit2=S, bit3=W)
//   yel  out  4  yellow lamp per approach (same mapping)
//   gre  out  4  green lamp per approach  (same mapping)
//
// Lamp outputs are registered. They are decoded from the next-state
// values so that they always match the state registers, and there is
// no combinational path from rst to any lamp.
module pro_1 #(
    parameter int unsigned GREEN_TIME  = 4,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] red,
    output logic [3:0] yel,
    output logic [3:0] gre
);

    // Counter sized to the longest phase, never narrower than 1 bit.
    localparam int unsigned MAX_GY = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
    localparam int unsigned MAX_T  = (MAX_GY > ALLRED_TIME) ? MAX_GY : ALLRED_TIME;
    localparam int unsigned CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    // Terminal count of each phase. The all-red value is unused when
    // the clearance phase is disabled.
    localparam logic [CW-1:0] G_LAST = CW'(GREEN_TIME - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] A_LAST = (ALLRED_TIME == 0) ? '0 : CW'(ALLRED_TIME - 1);

    // Phase encoding
    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_ALLRED = 2'd2;

    // Registered state
    logic [1:0]    r_dir;
    logic [1:0]    r_phase;
    logic [CW-1:0] r_count;
    logic [3:0]    r_red;
    logic [3:0]    r_yel;
    logic [3:0]    r_gre;

    // Next-state values
    logic [1:0]    w_dir_nxt;
    logic [1:0]    w_phase_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [3:0]    w_dir_oh;
    logic [3:0]    w_red_nxt;
    logic [3:0]    w_yel_nxt;
    logic [3:0]    w_gre_nxt;

    // Next-state logic: phase sequencing and per-phase dwell counter.
    always_comb begin
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        w_count_nxt = r_count + CW'(1);

        case (r_phase)
            PH_GREEN: begin
                if (r_count == G_LAST) begin
                    w_phase_nxt = PH_YELLOW;
                    w_count_nxt = '0;
                end
            end
            PH_YELLOW: begin
                if (r_count == Y_LAST) begin
                    w_count_nxt = '0;
                    if (ALLRED_TIME == 0) begin
                        // No clearance phase: hand over right-of-way immediately.
                        w_phase_nxt = PH_GREEN;
                        w_dir_nxt   = r_dir + 2'd1;
                    end else begin
                        w_phase_nxt = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (r_count == A_LAST) begin
                    w_phase_nxt = PH_GREEN;
                    w_dir_nxt   = r_dir + 2'd1;
                    w_count_nxt = '0;
                end
            end
            default: begin
                // Unused encoding: restart the current approach on green.
                w_phase_nxt = PH_GREEN;
                w_count_nxt = '0;
            end
        endcase
    end

    // Lamp decode of the next state, so the lamps are registered together with it.
    always_comb begin
        w_dir_oh  = 4'b0001 << w_dir_nxt;
        w_red_nxt = ~w_dir_oh;
        w_yel_nxt = 4'b0000;
        w_gre_nxt = 4'b0000;

        case (w_phase_nxt)
            PH_GREEN:  w_gre_nxt = w_dir_oh;
            PH_YELLOW: w_yel_nxt = w_dir_oh;
            default:   w_red_nxt = 4'b1111;
        endcase
    end

    // State and lamp registers. Reset discards any phase in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir   <= 2'd0;
            r_phase <= PH_GREEN;
            r_count <= '0;
            r_red   <= 4'b1110;
            r_yel   <= 4'b0000;
            r_gre   <= 4'b0001;
        end else begin
            r_dir   <= w_dir_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
            r_red   <= w_red_nxt;
            r_yel   <= w_yel_nxt;
            r_gre   <= w_gre_nxt;
        end
    end

    assign red = r_red;
    assign yel = r_yel;
    assign gre = r_gre;

endmodule

// File: tb/tb_pro_1.sv
// tb_pro_1: directed bench for pro_1. It runs a default-timing
// instance (4/2/1) and an overridden instance (2/1/0) from the same
// clock and reset. Lamp vectors are packed as {red, yel, gre}.
module tb_pro_1;

    logic       clk;
    logic       rst;
    logic [3:0] red1, yel1, gre1;
    logic [3:0] red2, yel2, gre2;

    int n_vec;
    int n_err;

    pro_1 u_dut1 (
        .clk (clk),
        .rst (rst),
        .red (red1),
        .yel (yel1),
        .gre (gre1)
    );

    pro_1 #(
        .GREEN_TIME  (2),
        .YELLOW_TIME (1),
        .ALLRED_TIME (0)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .red (red2),
        .yel (yel2),
        .gre (gre2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Lamp pattern for approach d in phase ph (0 green, 1 yellow, 2 all-red).
    function automatic logic [11:0] lamps(input int d, input int ph);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        case (ph)
            0:       return {~oh, 4'b0000, oh};
            1:       return {~oh, oh, 4'b0000};
            default: return {4'b1111, 4'b0000, 4'b0000};
        endcase
    endfunction

    // Default timing: 7 cycles per approach (4 green, 2 yellow, 1 all-red).
    function automatic logic [11:0] model1(input int t);
        int tt, p;
        tt = t % 28;
        p  = tt % 7;
        return lamps(tt / 7, (p < 4) ? 0 : (p < 6) ? 1 : 2);
    endfunction

    // Overridden timing: 3 cycles per approach (2 green, 1 yellow).
    function automatic logic [11:0] model2(input int t);
        int tt, p;
        tt = t % 12;
        p  = tt % 3;
        return lamps(tt / 3, (p < 2) ? 0 : 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] v1, v2, prev1;
    logic [11:0] hand [0:7];
    int          t;
    bit          ok;
    bit          prev_rst;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;

        // Reset held for several edges keeps the reset state.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold", {red1, yel1, gre1}, 12'hE01);
        end
        rst = 1'b0;
        t   = 0;

        // Hand-computed default vectors for cycles 0..7 after the reset edge.
        hand[0] = 12'hE01; hand[1] = 12'hE01; hand[2] = 12'hE01; hand[3] = 12'hE01;
        hand[4] = 12'hE10; hand[5] = 12'hE10; hand[6] = 12'hF00; hand[7] = 12'hD02;
        check("seq_t0", {red1, yel1, gre1}, hand[0]);
        check("p2_t0", {red2, yel2, gre2}, 12'hE01);
        for (int i = 1; i < 8; i++) begin
            step();
            t++;
            check($sformatf("seq_t%0d", i), {red1, yel1, gre1}, hand[i]);
        end

        // Full rotations for both instances, including the wrap from West to North.
        while (t < 67) begin
            step();
            t++;
            check($sformatf("rot1_t%0d", t), {red1, yel1, gre1}, model1(t));
            check($sformatf("rot2_t%0d", t), {red2, yel2, gre2}, model2(t));
            if (t == 28) check("wrap1_north", {8'h00, gre1}, 12'h001);
            if (t == 12) check("wrap2_north", {8'h00, gre2}, 12'h001);
            if (t == 21) check("west_green", {8'h00, gre1}, 12'h008);
        end

        // t=67 is East yellow on the default instance; reset from there.
        check("east_yel", {red1, yel1, gre1}, 12'hD20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_t0", {red1, yel1, gre1}, 12'hE01);
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("midrst_t%0d", i), {red1, yel1, gre1}, 12'hE01);
        end
        step();
        check("midrst_t4", {red1, yel1, gre1}, 12'hE10);
        t = 4;

        // Random reset pulses with lamp model and invariant checks.
        prev1    = {red1, yel1, gre1};
        prev_rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rst = ($urandom_range(15) == 0);
            step();
            t = rst ? 0 : t + 1;
            v1 = {red1, yel1, gre1};
            v2 = {red2, yel2, gre2};
            check("rnd1", v1, model1(t));
            check("rnd2", v2, model2(t));
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if ((32'(red1[i]) + 32'(yel1[i]) + 32'(gre1[i])) != 1) ok = 1'b0;
                if ((32'(red2[i]) + 32'(yel2[i]) + 32'(gre2[i])) != 1) ok = 1'b0;
                // Skip transition rules across a reset edge.
                if (!rst) begin
                    if (prev1[i] && v1[8+i]) ok = 1'b0;   // green -> red
                    if (prev1[4+i] && v1[i]) ok = 1'b0;   // yellow -> green
                end
            end
            if ($countones(~red1) > 1 || $countones(~red2) > 1) ok = 1'b0;
            check("invariant", {11'h000, ok}, 12'h001);
            prev1    = v1;
            prev_rst = rst;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pro_1.md
Name: pro_1

Overview:
- Fixed-time traffic-light controller for a four-way intersection.
- Grants right-of-way to one approach at a time in round-robin order: green, then yellow, then an optional all-red clearance, then the next approach.
- Self-contained timing source driving 4-bit red/yellow/green lamp buses, one bit per approach.
- No external request inputs; timing comes only from the clock.

Parameters:
- GREEN_TIME, 4: clock cycles an approach shows green; legal range >= 1.
- YELLOW_TIME, 2: clock cycles an approach shows yellow; legal range >= 1.
- ALLRED_TIME, 1: clock cycles all approaches show red after each yellow; 0 removes the clearance phase.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- red  output 4  red lamp per approach; bit0=North, bit1=East, bit2=South, bit3=West.
- yel  output 4  yellow lamp per approach; same bit mapping.
- gre  output 4  green lamp per approach; same bit mapping.

Behaviour:
- Reset and clocking:
  - One clock (clk); reset is synchronous and active-high (rst), sampled on the clk rising edge.
- State:
  - Registers: dir (2 bits, 0..3), phase (GREEN, YELLOW, ALLRED) and a phase counter.
  - Counter width: $clog2 of the largest timing parameter, minimum 1 bit.
- Reset:
  - A rising edge with rst=1 loads dir=0, phase=GREEN, count=0.
  - Resulting outputs: gre=4'b0001, yel=4'b0000, red=4'b1110.
  - Reset wins over any in-progress phase; there is no partial-phase carryover.
- Output decode:
  - Outputs are a pure decode of the registered state; no combinational path from rst to outputs.
  - GREEN: gre=onehot(dir), yel=0, red=~onehot(dir).
  - YELLOW: gre=0, yel=onehot(dir), red=~onehot(dir).
  - ALLRED: gre=0, yel=0, red=4'b1111.
- Timing:
  - Each phase holds for exactly its parameter count of cycles. count increments every cycle and clears on each phase change.
  - GREEN -> YELLOW when count==GREEN_TIME-1.
  - YELLOW -> ALLRED when count==YELLOW_TIME-1, or directly to GREEN of dir+1 if ALLRED_TIME==0.
  - ALLRED -> GREEN of dir+1 when count==ALLRED_TIME-1.
  - dir wraps modulo 4: West (3) -> North (0).
- Full rotation period: 4*(GREEN_TIME+YELLOW_TIME+ALLRED_TIME) cycles, which is 28 with defaults.
- Invariants, every cycle after the first reset edge:
  - For each bit i, exactly one of red[i], yel[i], gre[i] is 1.
  - At most one approach is non-red.
  - Green is never directly followed by red on the same approach without yellow.
  - Yellow is never followed by green on the same approach.
- Outputs are undefined before the first reset edge. They must be X-free thereafter.
- Reset held for multiple cycles keeps the reset state.

Test Plan:
- Reset: rst=1 for one rising edge, then 0 -> gre=0001, yel=0000, red=1110 at the edge and held for 4 cycles total including that edge.
- Default sequence after rst release:
  - Cycles 1-3 continue North green.
  - Cycles 4-5: yel=0001, red=1110.
  - Cycle 6: red=1111.
  - Cycle 7: gre=0010, red=1101 (East green).
- Wrap-around: run 28+ cycles -> sequence N,E,S,W green (gre 0001,0010,0100,1000), then North green again exactly 28 cycles after the first North green.
- Mid-operation reset: assert rst during East yellow -> next edge gre=0001, red=1110, count restarts; North green lasts 4 full cycles.
- Parameter override (GREEN_TIME=2, YELLOW_TIME=1, ALLRED_TIME=0) -> per approach 2 green + 1 yellow, no all-red cycles, rotation period 12 cycles.
- Invariant checker over 200 cycles with random rst pulses -> one-hot-per-approach lamp state and at most one non-red approach, with no violations.
